// File: rtl/subword_mem_bridge_if.sv
// Bundle of CPU-side request/response signals and RAM-side port signals
// for the sub-word load/store bridge. The slave modport is the bridge; the
// master modport is the CPU datapath plus the word RAM that surround it.
interface subword_mem_bridge_if #(
  parameter int ADDR_W = 32
);
  // CPU request, held stable by the CPU while it waits for done
  logic              req;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_uns;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  // CPU response
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;

  // Word RAM port
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // FSM state, exported for observation only
  logic [2:0]        state;

  modport slave (
    input  req, req_we, req_size, req_uns, req_addr, req_wdata, mem_rdata,
    output busy, done, err, rdata, mem_addr, mem_re, mem_we, mem_wdata, state
  );

  modport master (
    output req, req_we, req_size, req_uns, req_addr, req_wdata, mem_rdata,
    input  busy, done, err, rdata, mem_addr, mem_re, mem_we, mem_wdata, state
  );
endinterface

// File: rtl/subword_mem_bridge.sv
// Load/store bridge between the CPU datapath and a word-only synchronous RAM.
// Loads read a word, pick the addressed byte/half lane and sign/zero extend.
// Word stores write straight through; byte/half stores read the containing
// word, merge the new lane in and write the whole word back.
//
// Handshake: the CPU raises req with its command fields; the bridge samples
// them only on a clock edge where it is IDLE, then holds busy high until the
// single-cycle done pulse (with err qualifying it). req seen while busy, or
// during the done cycle, is ignored; the command is never re-sampled mid-op.
module subword_mem_bridge #(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input logic                  clk,
  input logic                  rst,
  subword_mem_bridge_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  logic [2:0]        state;
  logic              op_we;
  logic [1:0]        op_size;
  logic              op_uns;
  logic [1:0]        op_lane;
  logic [31:0]       op_wdata;
  logic [ADDR_W-3:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              err_r;
  logic [31:0]       rdata_r;

  logic              out_of_range;
  logic              req_err;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_val;
  logic [31:0]       merge_val;

  // Range check on the word index so no multiply/shift of the byte limit is needed
  assign out_of_range = ({2'b00, bus.req_addr[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS));

  // Classify the incoming request as an error access before any RAM traffic
  always_comb begin
    req_err = 1'b0;
    if (bus.req_size == SZ_BAD) begin
      req_err = 1'b1;
    end
    if ((bus.req_size == SZ_HALF) && bus.req_addr[0]) begin
      req_err = 1'b1;
    end
    if ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
    if (out_of_range) begin
      req_err = 1'b1;
    end
  end

  // Pick the addressed little-endian byte and half out of the RAM read word
  always_comb begin
    byte_sel = 8'h00;
    case (op_lane)
      2'd0:    byte_sel = bus.mem_rdata[7:0];
      2'd1:    byte_sel = bus.mem_rdata[15:8];
      2'd2:    byte_sel = bus.mem_rdata[23:16];
      default: byte_sel = bus.mem_rdata[31:24];
    endcase
    half_sel = op_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  end

  // Sign or zero extend the selected lane into the load result
  always_comb begin
    load_val = bus.mem_rdata;
    case (op_size)
      SZ_BYTE: load_val = op_uns ? {24'h000000, byte_sel}
                                 : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_val = op_uns ? {16'h0000, half_sel}
                                 : {{16{half_sel[15]}}, half_sel};
      default: load_val = bus.mem_rdata;
    endcase
  end

  // Overlay the low store-data bits onto the addressed lane of the read word
  always_comb begin
    merge_val = bus.mem_rdata;
    if (op_size == SZ_BYTE) begin
      case (op_lane)
        2'd0:    merge_val[7:0]   = op_wdata[7:0];
        2'd1:    merge_val[15:8]  = op_wdata[7:0];
        2'd2:    merge_val[23:16] = op_wdata[7:0];
        default: merge_val[31:24] = op_wdata[7:0];
      endcase
    end else if (op_size == SZ_HALF) begin
      if (op_lane[1]) begin
        merge_val[31:16] = op_wdata[15:0];
      end else begin
        merge_val[15:0] = op_wdata[15:0];
      end
    end
  end

  // Access sequencer: latch command in IDLE, walk RD/CAP/WR as needed, pulse in FIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_we       <= 1'b0;
      op_size     <= SZ_BYTE;
      op_uns      <= 1'b0;
      op_lane     <= 2'd0;
      op_wdata    <= 32'h0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h0;
      err_r       <= 1'b0;
      rdata_r     <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            op_we    <= bus.req_we;
            op_size  <= bus.req_size;
            op_uns   <= bus.req_uns;
            op_lane  <= bus.req_addr[1:0];
            op_wdata <= bus.req_wdata;
            if (req_err) begin
              // Error accesses never touch the RAM port registers
              err_r <= 1'b1;
              state <= S_FIN;
            end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
              mem_addr_r  <= bus.req_addr[ADDR_W-1:2];
              mem_wdata_r <= bus.req_wdata;
              state       <= S_WR;
            end else begin
              mem_addr_r <= bus.req_addr[ADDR_W-1:2];
              state      <= S_RD;
            end
          end
        end
        S_RD: begin
          state <= S_CAP;
        end
        S_CAP: begin
          if (op_we) begin
            mem_wdata_r <= merge_val;
            state       <= S_WR;
          end else begin
            rdata_r <= load_val;
            state   <= S_FIN;
          end
        end
        S_WR: begin
          state <= S_FIN;
        end
        S_FIN: begin
          err_r <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          err_r <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are pure state decodes so a reset edge removes them immediately
  assign bus.busy      = (state != S_IDLE);
  assign bus.mem_re    = (state == S_RD);
  assign bus.mem_we    = (state == S_WR);
  assign bus.done      = (state == S_FIN);
  assign bus.err       = err_r;
  assign bus.rdata     = rdata_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.state     = state;

  // The RAM port is never read and written in the same cycle
  a_re_we_exclusive: assert property (@(posedge clk) !(bus.mem_re && bus.mem_we));

  // err is only ever visible alongside done
  a_err_with_done: assert property (@(posedge clk) bus.err |-> bus.done);

endmodule
